fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, FFT points (power of 2, 8..1024); L = log2(N).
REQ-002 SHALL have parameter STAGE, default 0, R2MDC stage index (0..L-2).
REQ-003 SHALL have parameter BF_LAT, default 1, cycles from bf_en to butterfly result (0..4).
REQ-004 SHALL derive FRAME = N/2 pair-cycles per frame and D = FRAME >> (STAGE+1) delay depth.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  sample pair present on both rails this cycle.
REQ-009 in_sop  input  1  qualifies first pair of a frame (meaningful only with in_valid).
REQ-010 in_ready  output  1  controller accepts input; in_valid ignored when low.
REQ-011 dl_wr_en  output  1  delay-line write/shift enable.
REQ-012 comm_sel  output  1  delay commutator select.
REQ-013 bf_en  output  1  butterfly operation issued this cycle.
REQ-014 tw_addr  output  L-1  twiddle ROM address for the issued op.
REQ-015 out_valid  output  1  butterfly result valid.
REQ-016 out_sop  output  1  first result of a frame.
REQ-017 frame_err  output  1  one-cycle framing error pulse.

Function
REQ-018 SHALL implement states IDLE, FILL, RUN, FLUSH with counters icnt (input pair index, 0..FRAME-1) and ocnt (op index, 0..FRAME-1).
REQ-019 "accepted" SHALL mean in_valid AND in_ready; all counters and state SHALL hold on non-accepted cycles in IDLE/FILL/RUN.
REQ-020 in_ready SHALL be 0 in FLUSH, 1 otherwise.
REQ-021 IDLE: accepted in_sop -> FILL, icnt=1; accepted without in_sop -> frame_err pulse, stay IDLE.
REQ-022 FILL: each accepted pair increments icnt; bf_en=0; on the accept that makes icnt==D -> RUN with ocnt=0.
REQ-023 RUN: each accepted pair increments icnt (mod FRAME) and issues one op (bf_en=1, ocnt increments mod FRAME after issue).
REQ-024 At frame boundary (RUN, icnt==0): accepted in_sop continues RUN (back-to-back, no refill); accepted without in_sop -> frame_err pulse and FLUSH; no accept -> FLUSH.
REQ-025 Accepted in_sop in FILL, or in RUN with icnt!=0, SHALL pulse frame_err, discard current frame, set icnt=1, ocnt=0, enter FILL.
REQ-026 FLUSH: bf_en=1 every cycle for exactly D cycles (ocnt increments), then IDLE.
REQ-027 tw_addr SHALL equal (ocnt mod (N>>(STAGE+1))) << STAGE, combinationally from registered ocnt; value don't-care when bf_en=0 but SHALL hold its last value.
REQ-028 comm_sel SHALL equal bit log2(D) of icnt; 0 in IDLE.
REQ-029 dl_wr_en SHALL equal accepted in FILL/RUN, and 1 every FLUSH cycle.
REQ-030 out_valid SHALL be bf_en delayed exactly BF_LAT cycles; out_sop SHALL be (bf_en AND ocnt==0) delayed BF_LAT cycles.
REQ-031 All outputs except tw_addr/comm_sel/in_ready SHALL be registered or pure state decodes; no combinational in_valid->in_ready path.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, icnt=ocnt=0, delay pipe cleared: bf_en, dl_wr_en, comm_sel, out_valid, out_sop, frame_err=0, tw_addr=0, in_ready=1.
REQ-033 Reset asserted mid-frame or mid-FLUSH SHALL discard all in-flight ops (no out_valid after release until a new frame issues).

Verification (N=16, STAGE=0, BF_LAT=1: FRAME=8, D=4)
REQ-034 Single frame, 8 consecutive accepts from in_sop -> bf_en low 4 cycles, then 4 ops tw_addr 0..3, FLUSH 4 ops tw_addr 4..7 with in_ready=0; 8 out_valid pulses one cycle after bf_en, out_sop once; IDLE after.
REQ-035 Two back-to-back frames (16 accepts, sop at 1 and 9) -> bf_en continuous from cycle 5 to cycle 20, tw_addr 0..7,0..7, two out_sop pulses, no frame_err.
REQ-036 in_valid low 3 cycles after 2nd RUN op -> bf_en, dl_wr_en low 3 cycles, tw_addr/comm_sel/icnt held, sequence resumes unchanged.
REQ-037 in_sop at icnt=5 -> frame_err one cycle, FILL restarts, next bf_en after 3 further accepts with tw_addr 0.
REQ-038 comm_sel toggles 0,1 every 4 accepted pairs through a frame.
REQ-039 rst_n low during FLUSH cycle 2 -> outputs zero immediately, in_ready=1, no out_valid after release.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// R2MDC single-stage controller: sequences delay-line fill, butterfly issue,
// commutator select and end-of-stream flush for one radix-2 MDC stage, and
// tags butterfly results with valid/start-of-frame after the butterfly latency.
// All per-cycle strobes are registered; they reflect the decision made at the
// preceding clock edge, so an accept at edge k is visible after edge k.
module fft_stage_ctrl #(
    parameter int N      = 16,
    parameter int STAGE  = 0,
    parameter int BF_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    output logic                   in_ready,
    output logic                   dl_wr_en,
    output logic                   comm_sel,
    output logic                   bf_en,
    output logic [$clog2(N)-2:0]   tw_addr,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   frame_err
);

    localparam int L     = $clog2(N);
    localparam int CW    = L - 1;
    localparam int FRAME = N / 2;
    localparam int D     = FRAME >> (STAGE + 1);
    localparam int LOGD  = $clog2(D);
    localparam int TWM   = N >> (STAGE + 1);

    localparam logic [CW-1:0] D_C     = CW'(D);
    localparam logic [CW-1:0] TW_MASK = CW'(TWM - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] icnt, icnt_nxt;
    logic [CW-1:0] ocnt, ocnt_nxt;
    logic          accept;
    logic          issue;
    logic          wr;
    logic          err;
    logic          bf_sop;

    // Twiddle index for op number op: wraps at the stage's twiddle period and
    // is scaled by the stage index so all stages share one full-size ROM.
    function automatic logic [CW-1:0] tw_of(input logic [CW-1:0] op);
        return (op & TW_MASK) << STAGE;
    endfunction

    assign in_ready = (state != S_FLUSH);
    assign accept   = in_valid && in_ready;
    assign comm_sel = (state != S_IDLE) && icnt[LOGD];

    // Next-state, counter and strobe decisions for the coming edge.
    always_comb begin
        state_nxt = state;
        icnt_nxt  = icnt;
        ocnt_nxt  = ocnt;
        issue     = 1'b0;
        wr        = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        wr        = 1'b1;
                        icnt_nxt  = CW'(1);
                        ocnt_nxt  = '0;
                        state_nxt = (D == 1) ? S_RUN : S_FILL;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    wr = 1'b1;
                    if (in_sop) begin
                        // Early sop: drop the partial frame and refill from this pair.
                        err       = 1'b1;
                        icnt_nxt  = CW'(1);
                        ocnt_nxt  = '0;
                        state_nxt = (D == 1) ? S_RUN : S_FILL;
                    end else begin
                        icnt_nxt = icnt + 1'b1;
                        if (icnt + 1'b1 == D_C) begin
                            state_nxt = S_RUN;
                            ocnt_nxt  = '0;
                        end
                    end
                end
            end
            S_RUN: begin
                if (icnt == '0) begin
                    if (accept && in_sop) begin
                        // Back-to-back frame: the delay line is already primed.
                        wr       = 1'b1;
                        issue    = 1'b1;
                        icnt_nxt = icnt + 1'b1;
                        ocnt_nxt = ocnt + 1'b1;
                    end else begin
                        // Stream ended (or broke): first flush op issues right now
                        // so the butterfly stream stays gap-free.
                        err       = accept;
                        issue     = 1'b1;
                        wr        = 1'b1;
                        ocnt_nxt  = ocnt + 1'b1;
                        state_nxt = S_FLUSH;
                    end
                end else if (accept) begin
                    wr = 1'b1;
                    if (in_sop) begin
                        err       = 1'b1;
                        icnt_nxt  = CW'(1);
                        ocnt_nxt  = '0;
                        state_nxt = (D == 1) ? S_RUN : S_FILL;
                    end else begin
                        issue    = 1'b1;
                        icnt_nxt = icnt + 1'b1;
                        ocnt_nxt = ocnt + 1'b1;
                    end
                end
            end
            default: begin
                // FLUSH drains the remaining ops of the frame; ocnt wraps to 0
                // exactly after the D-th flush op, which ends the flush.
                if (ocnt != '0) begin
                    issue    = 1'b1;
                    wr       = 1'b1;
                    ocnt_nxt = ocnt + 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State, counters and registered control strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            icnt      <= '0;
            ocnt      <= '0;
            bf_en     <= 1'b0;
            bf_sop    <= 1'b0;
            dl_wr_en  <= 1'b0;
            frame_err <= 1'b0;
            tw_addr   <= '0;
        end else begin
            state     <= state_nxt;
            icnt      <= icnt_nxt;
            ocnt      <= ocnt_nxt;
            bf_en     <= issue;
            bf_sop    <= issue && (ocnt == '0);
            dl_wr_en  <= wr;
            frame_err <= err;
            if (issue) begin
                tw_addr <= tw_of(ocnt);
            end
        end
    end

    generate
        if (BF_LAT == 0) begin : g_nolat
            assign out_valid = bf_en;
            assign out_sop   = bf_sop;
        end else begin : g_lat
            logic [BF_LAT-1:0] vld_p;
            logic [BF_LAT-1:0] sop_p;

            // Result-tag delay matching the butterfly pipeline depth.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                    sop_p <= '0;
                end else begin
                    vld_p[0] <= bf_en;
                    sop_p[0] <= bf_sop;
                    for (int i = 1; i < BF_LAT; i++) begin
                        vld_p[i] <= vld_p[i-1];
                        sop_p[i] <= sop_p[i-1];
                    end
                end
            end

            assign out_valid = vld_p[BF_LAT-1];
            assign out_sop   = sop_p[BF_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at N=16, STAGE=0, BF_LAT=1 (FRAME=8, D=4).
// Each step drives inputs, waits one rising edge, then samples 1 time unit later.
// Observed vector: {in_ready, bf_en, dl_wr_en, comm_sel, out_valid, out_sop, frame_err, tw_addr[2:0]}.
module tb_fft_stage_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic       dl_wr_en;
    logic       comm_sel;
    logic       bf_en;
    logic [2:0] tw_addr;
    logic       out_valid;
    logic       out_sop;
    logic       frame_err;

    int n_cmp;
    int n_err;

    localparam logic [9:0] RST_VEC = 10'b1000000000;

    fft_stage_ctrl #(.N(16), .STAGE(0), .BF_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_ready  (in_ready),
        .dl_wr_en  (dl_wr_en),
        .comm_sel  (comm_sel),
        .bf_en     (bf_en),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {in_ready, bf_en, dl_wr_en, comm_sel, out_valid, out_sop, frame_err, tw_addr};
    endfunction

    // Hand-derived outputs after step k of a lone frame (sop at step 1, 8 accepts).
    function automatic logic [9:0] sf_exp(input int k);
        logic       rdy, bf, wr, cs, ov, os;
        logic [2:0] tw;
        int         ic;
        rdy = !(k >= 9 && k <= 12);
        bf  = (k >= 5 && k <= 12);
        wr  = (k >= 1 && k <= 12);
        ic  = (k <= 8) ? (k % 8) : 0;
        cs  = (ic >= 4);
        ov  = (k >= 6 && k <= 13);
        os  = (k == 6);
        tw  = (k < 5) ? 3'd0 : (k <= 12) ? 3'(k - 5) : 3'd7;
        return {rdy, bf, wr, cs, ov, os, 1'b0, tw};
    endfunction

    task automatic step(input logic v, input logic s);
        in_valid = v;
        in_sop   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = obs();
        n_cmp++;
        if (got !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_state got %b want %b", got, RST_VEC);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            step(k <= 8, k == 1);
            got = obs();
            exp = sf_exp(k);
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL single_frame step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got, exp;
        logic       rdy, bf, wr, cs, ov, os;
        logic [2:0] tw;
        int         ic;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            step(k <= 16, (k == 1) || (k == 9));
            rdy = !(k >= 17 && k <= 20);
            bf  = (k >= 5 && k <= 20);
            wr  = (k <= 20);
            ic  = (k <= 16) ? (k % 8) : 0;
            cs  = (ic >= 4);
            ov  = (k >= 6 && k <= 21);
            os  = (k == 6) || (k == 14);
            tw  = (k < 5) ? 3'd0 : (k <= 20) ? 3'((k - 5) % 8) : 3'd7;
            exp = {rdy, bf, wr, cs, ov, os, 1'b0, tw};
            got = obs();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL back_to_back step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            if (k <= 6) begin
                step(1'b1, k == 1);
                exp = sf_exp(k);
            end else if (k <= 9) begin
                step(1'b0, 1'b0);
                // Held: icnt=6 (comm_sel 1), tw_addr 1; only the last op's result drains.
                exp = {1'b1, 1'b0, 1'b0, 1'b1, (k == 7), 1'b0, 1'b0, 3'd1};
            end else begin
                step(k <= 11, 1'b0);
                exp = sf_exp(k - 3);
                if (k == 10) exp[5] = 1'b0;
            end
            got = obs();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL stall step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_midframe_sop();
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            step(1'b1, (k == 1) || (k == 6));
            case (k)
                6:       exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
                7, 8:    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
                9:       exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
                10:      exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
                11:      exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1};
                default: exp = sf_exp(k);
            endcase
            got = obs();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL midframe_sop step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_idle_no_sop();
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step(k != 2, k == 3);
            case (k)
                1:       exp = 10'b1000001000;
                2:       exp = 10'b1000000000;
                default: exp = 10'b1010000000;
            endcase
            got = obs();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL idle_no_sop step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_boundary_err();
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step(k <= 9, k == 1);
            exp = sf_exp(k);
            if (k == 9) exp[3] = 1'b1;
            got = obs();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL boundary_err step %0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_flush_reset();
        logic [9:0] got;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(k <= 8, k == 1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== RST_VEC) begin
            n_err++;
            $display("FAIL flush_reset_async got %b want %b", got, RST_VEC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0);
            got = obs();
            n_cmp++;
            if (got !== RST_VEC) begin
                n_err++;
                $display("FAIL flush_reset_after step %0d got %b want %b", k, got, RST_VEC);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_midframe_sop();
        test_idle_no_sop();
        test_boundary_err();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
